// File: rtl/alu_pipe_unit.sv
// Pipelined integer ALU functional unit with a valid/ready pipeline, flush and ROB tag.
// Define ALU_PIPE_OVF_EN to add the signed-overflow output ovf_o.
`timescale 1ns/1ps
module alu_pipe_unit #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             neg_o,
`ifdef ALU_PIPE_OVF_EN
    output logic             ovf_o,
`endif
    output logic             ready_o
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             zf;
        logic             nf;
`ifdef ALU_PIPE_OVF_EN
        logic             of;
`endif
    } stage_t;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    stage_t           cap;

    always_comb begin
        sh  = b_i[SHW-1:0];
        res = '0;
        case (op_i)
            4'd0:    res = a_i + b_i;
            4'd1:    res = a_i - b_i;
            4'd2:    res = a_i & b_i;
            4'd3:    res = a_i | b_i;
            4'd4:    res = a_i ^ b_i;
            4'd5:    res = a_i << sh;
            4'd6:    res = a_i >> sh;
            4'd7:    res = $signed(a_i) >>> sh;
            4'd8:    res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            4'd9:    res = {{(WIDTH-1){1'b0}}, a_i < b_i};
            default: res = '0;
        endcase
    end

    always_comb begin
        cap      = '0;
        cap.data = res;
        cap.tag  = tag_i;
        cap.zf   = (res == '0);
        cap.nf   = res[WIDTH-1];
`ifdef ALU_PIPE_OVF_EN
        // Overflow: result sign disagrees with A when the effective operand signs match.
        cap.of   = ((op_i == 4'd0) && (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]))
                || ((op_i == 4'd1) && (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]));
`endif
    end

    logic [STAGES-1:0] vld_q, vld_d, adv;
    stage_t            pl_q [STAGES];
    stage_t            pl_d [STAGES];

    assign adv[LAST] = vld_q[LAST] & ready_i;
    assign ready_o   = ~vld_q[0] | adv[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi < LAST) begin : g_adv
                // A stage moves if the sink accepts or any bubble exists downstream.
                assign adv[gi] = vld_q[gi] & (ready_i | ~(&vld_q[LAST:gi+1]));
            end
            if (gi == 0) begin : g_head
                assign vld_d[gi] = flush_i ? 1'b0 : (ready_o ? valid_i : vld_q[gi]);
                assign pl_d[gi]  = (ready_o && valid_i) ? cap : pl_q[gi];
            end else begin : g_body
                logic take;
                assign take      = ~vld_q[gi] | adv[gi];
                assign vld_d[gi] = flush_i ? 1'b0 : (take ? vld_q[gi-1] : vld_q[gi]);
                assign pl_d[gi]  = adv[gi-1] ? pl_q[gi-1] : pl_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) pl_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) pl_q[k] <= pl_d[k];
        end
    end

    assign valid_o = vld_q[LAST];
    assign data_o  = pl_q[LAST].data;
    assign tag_o   = pl_q[LAST].tag;
    assign zero_o  = pl_q[LAST].zf;
    assign neg_o   = pl_q[LAST].nf;
`ifdef ALU_PIPE_OVF_EN
    assign ovf_o   = pl_q[LAST].of;
`endif

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Scoreboard bench for alu_pipe_unit: 32-bit/2-stage main instance plus an 8-bit/1-stage instance.
`timescale 1ns/1ps
module tb_alu_pipe_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, flush_i, valid_i, ready_i, ready_o, valid_o, zero_o, neg_o;
    logic [3:0]  op_i;
    logic [31:0] a_i, b_i, data_o;
    logic [5:0]  tag_i, tag_o;
`ifdef ALU_PIPE_OVF_EN
    logic        ovf_o, ovf8;
`endif
    logic        v8, rdy8, rdyo8, vo8, z8, n8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, d8;
    logic [5:0]  t8;

    alu_pipe_unit #(.WIDTH(32), .TAG_W(6), .STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .ready_i(ready_i), .valid_o(valid_o),
        .data_o(data_o), .tag_o(tag_o), .zero_o(zero_o), .neg_o(neg_o),
`ifdef ALU_PIPE_OVF_EN
        .ovf_o(ovf_o),
`endif
        .ready_o(ready_o)
    );

    alu_pipe_unit #(.WIDTH(8), .TAG_W(6), .STAGES(1)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(1'b0), .valid_i(v8), .op_i(op8),
        .a_i(a8), .b_i(b8), .tag_i(t8), .ready_i(rdy8), .valid_o(vo8),
        .data_o(d8), .tag_o(), .zero_o(z8), .neg_o(n8),
`ifdef ALU_PIPE_OVF_EN
        .ovf_o(ovf8),
`endif
        .ready_o(rdyo8)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vec_t vecs [15] = '{
        '{4'd1,  32'd5,        32'd5,        32'h0000_0000, 1'b0},
        '{4'd8,  32'hFFFF_FFFF, 32'd1,        32'h0000_0001, 1'b0},
        '{4'd9,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0},
        '{4'd7,  32'h8000_0000, 32'h24,       32'hF800_0000, 1'b0},
        '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
        '{4'd3,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0},
        '{4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0},
        '{4'd5,  32'h0000_0001, 32'h1F,       32'h8000_0000, 1'b0},
        '{4'd6,  32'h8000_0000, 32'h21,       32'h4000_0000, 1'b0},
        '{4'd12, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0},
        '{4'd1,  32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b1},
        '{4'd0,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0},
        '{4'd15, 32'd5,        32'd5,        32'h0000_0000, 1'b0},
        '{4'd8,  32'd1,        32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{4'd7,  32'h7FFF_FFF0, 32'd4,        32'h07FF_FFFF, 1'b0}
    };

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: every delivered result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got data %0h tag %0d, required no result", data_o, tag_o);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 64'(data_o), 64'(e.data));
                    chk("res_tag",  64'(tag_o),  64'(e.tag));
                    chk("res_zero", 64'(zero_o), 64'(e.data == 32'd0));
                    chk("res_neg",  64'(neg_o),  64'(e.data[31]));
`ifdef ALU_PIPE_OVF_EN
                    chk("res_ovf",  64'(ovf_o),  64'(e.ovf));
`endif
                    $display("result tag %0d data %08h", tag_o, data_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [31:0] ed, input logic eo,
                         input bit push, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; tag_i = tag;
        while (!acc) begin
            @(negedge clk);
            if (ready_o) begin
                acc = 1'b1;
                if (push) sb.push_back(exp_t'{ed, tag, eo});
                $display("issue op %0d a %08h b %08h tag %0d", op, a, b, tag);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
            if (!acc && waits > 20) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: got no accept after %0d cycles, required accept", waits);
                acc = 1'b1;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int w;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = '0; a_i = '0; b_i = '0; tag_i = '0;
        v8 = 1'b0; rdy8 = 1'b1; op8 = '0; a8 = '0; b8 = '0; t8 = '0;
        #12;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data",  64'(data_o),  64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid8", 64'(vo8), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        cycles(1);
        chk("post_rst_ready", 64'(ready_o), 64'd1);

        // ADD overflow case with latency check
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 6'd5, 32'h8000_0000, 1'b1, 1'b1, w);
        valid_i = 1'b0;
        chk("lat_early", 64'(valid_o), 64'd0);
        cycles(1);
        chk("lat_ontime", 64'(valid_o), 64'd1);
        cycles(2);

        // Back-to-back directed vectors at full throughput
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 6'(i + 1), vecs[i].ed, vecs[i].eo, 1'b1, w);
            chk("b2b_wait", 64'(w), 64'd0);
        end
        valid_i = 1'b0;
        cycles(4);

        // Fill with sink stalled, hold, then retire and accept on the same edge
        ready_i = 1'b0;
        issue(4'd0, 32'd1, 32'd2, 6'd20, 32'd3, 1'b0, 1'b1, w);
        issue(4'd4, 32'hAA, 32'h55, 6'd21, 32'hFF, 1'b0, 1'b1, w);
        valid_i = 1'b0;
        chk("full_ready", 64'(ready_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("stall_valid", 64'(valid_o), 64'd1);
            chk("stall_data",  64'(data_o),  64'd3);
            chk("stall_tag",   64'(tag_o),   64'd20);
        end
        ready_i = 1'b1;
        issue(4'd3, 32'h100, 32'h1, 6'd22, 32'h101, 1'b0, 1'b1, w);
        chk("full_accept_retire", 64'(w), 64'd0);
        valid_i = 1'b0;
        cycles(4);

        // Flush: two in flight plus one presented, then flush on an empty pipe
        ready_i = 1'b0;
        issue(4'd0, 32'd7, 32'd7, 6'd30, 32'd14, 1'b0, 1'b0, w);
        issue(4'd0, 32'd8, 32'd8, 6'd31, 32'd16, 1'b0, 1'b0, w);
        op_i = 4'd0; a_i = 32'd9; b_i = 32'd9; tag_i = 6'd32; valid_i = 1'b1;
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);
        op_i = 4'd0; a_i = 32'd10; b_i = 32'd10; tag_i = 6'd33; valid_i = 1'b1;
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0; valid_i = 1'b0;
        ready_i = 1'b1;
        cycles(4);
        chk("flush_drop_valid", 64'(valid_o), 64'd0);
        issue(4'd1, 32'd100, 32'd1, 6'd34, 32'd99, 1'b0, 1'b1, w);
        valid_i = 1'b0;
        cycles(4);

        // Asynchronous reset with results waiting at the output
        ready_i = 1'b0;
        issue(4'd0, 32'h8000_0000, 32'h1234, 6'd40, 32'h8000_1234, 1'b0, 1'b0, w);
        issue(4'd0, 32'h11, 32'h22, 6'd41, 32'h33, 1'b0, 1'b0, w);
        valid_i = 1'b0;
        chk("pre_rst_valid", 64'(valid_o), 64'd1);
        @(negedge clk); #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_data",  64'(data_o),  64'd0);
        chk("arst_tag",   64'(tag_o),   64'd0);
        chk("arst_zero",  64'(zero_o),  64'd0);
        chk("arst_neg",   64'(neg_o),   64'd0);
        chk("arst_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        ready_i = 1'b1;
        cycles(3);
        chk("post_arst_valid", 64'(valid_o), 64'd0);

        // 8-bit, single-stage instance: one-cycle latency and shift masking
        begin
            logic [3:0] o8 [4] = '{4'd5, 4'd7, 4'd9, 4'd0};
            logic [7:0] x8 [4] = '{8'h01, 8'h80, 8'h01, 8'h7F};
            logic [7:0] y8 [4] = '{8'h09, 8'h03, 8'h02, 8'h01};
            logic [7:0] r8 [4] = '{8'h02, 8'hF0, 8'h01, 8'h80};
            for (int i = 0; i < 4; i++) begin
                v8 = 1'b1; op8 = o8[i]; a8 = x8[i]; b8 = y8[i]; t8 = 6'(i);
                @(negedge clk);
                chk("w8_ready", 64'(rdyo8), 64'd1);
                @(posedge clk); #1;
                chk("w8_valid", 64'(vo8), 64'd1);
                chk("w8_data",  64'(d8),  64'(r8[i]));
                chk("w8_zero",  64'(z8),  64'(r8[i] == 8'd0));
                chk("w8_neg",   64'(n8),  64'(r8[i][7]));
`ifdef ALU_PIPE_OVF_EN
                chk("w8_ovf",   64'(ovf8), 64'(i == 3));
`endif
                $display("w8 op %0d a %02h b %02h -> %02h", o8[i], x8[i], y8[i], d8);
            end
            v8 = 1'b0;
            cycles(1);
            chk("w8_idle", 64'(vo8), 64'd0);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
